// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - in-order write-back buffer between cache evictions and data memory
//
// Holds evicted dirty lines in a small circular FIFO and drains them one at a
// time to data memory, while answering combinational refill lookups.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   push_valid/addr/data, push_ready   evicted-line push from the cache
//   lookup_addr -> lookup_hit/data     same-cycle forwarding of buffered lines
//   mem_is_input_valid, mem_write,
//   mem_addr, mem_din, mem_ready       one line write at a time to data memory
//   is_empty                        nothing buffered and drain FSM idle
module writeback_buffer #(
   parameter int LINE_SIZE = 16,
   parameter int DEPTH     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_valid,
   input  logic [31:0]            push_addr,
   input  logic [LINE_SIZE*8-1:0] push_data,
   output logic                   push_ready,
   input  logic [31:0]            lookup_addr,
   output logic                   lookup_hit,
   output logic [LINE_SIZE*8-1:0] lookup_data,
   output logic                   mem_is_input_valid,
   output logic [31:0]            mem_addr,
   output logic                   mem_write,
   output logic [LINE_SIZE*8-1:0] mem_din,
   input  logic                   mem_ready,
   output logic                   is_empty
);

   localparam int OFS = $clog2(LINE_SIZE);
   localparam int LW  = LINE_SIZE * 8;
   localparam int PW  = $clog2(DEPTH);
   localparam int TW  = 32 - OFS;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state, state_next;
   logic [DEPTH-1:0]  valid;
   logic [TW-1:0]     tag_mem  [DEPTH];
   logic [LW-1:0]     data_mem [DEPTH];
   logic [PW-1:0]     head, tail;
   logic [PW:0]       count, count_next;

   logic [TW-1:0]     push_tag, look_tag;
   logic              coal_hit, look_hit;
   logic [PW-1:0]     coal_sel, look_sel, idx;
   logic              push_fire, handshake;
   logic              unused_offset_bits;

   assign push_tag = push_addr[31:OFS];
   assign look_tag = lookup_addr[31:OFS];
   assign unused_offset_bits = ^{push_addr[OFS-1:0], lookup_addr[OFS-1:0]};

   // Walk entries oldest to youngest so the last match found is the youngest.
   // The head entry is excluded as a coalesce target while it is being issued,
   // since memory may already be consuming its data.
   always_comb begin
      coal_hit = 1'b0;
      coal_sel = '0;
      look_hit = 1'b0;
      look_sel = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (valid[idx] && tag_mem[idx] == push_tag && !(state == ISSUE && k == 0)) begin
            coal_hit = 1'b1;
            coal_sel = idx;
         end
         if (valid[idx] && tag_mem[idx] == look_tag) begin
            look_hit = 1'b1;
            look_sel = idx;
         end
      end
   end

   assign lookup_hit  = look_hit;
   assign lookup_data = look_hit ? data_mem[look_sel] : '0;

   // Uses the registered count, so a slot freed by this cycle's pop is not
   // reusable until the next cycle.
   assign push_ready = !reset && ((count < FULL) || coal_hit);
   assign push_fire  = push_valid && push_ready;
   assign handshake  = (state == ISSUE) && mem_ready;

   always_comb begin
      count_next = count;
      if (push_fire && !coal_hit) count_next = count_next + 1'b1;
      if (handshake)              count_next = count_next - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next         = state;
      mem_is_input_valid = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) state_next = ISSUE;
         end
         ISSUE: begin
            mem_is_input_valid = 1'b1;
            if (handshake && count_next == '0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_write = mem_is_input_valid;
   assign mem_addr  = {tag_mem[head], {OFS{1'b0}}};
   assign mem_din   = data_mem[head];
   assign is_empty  = (count == '0) && (state == IDLE);

   // An append never targets the head slot during a pop: appends need
   // count < DEPTH and a pop needs count > 0, so tail != head then.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (handshake) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         if (push_fire) begin
            if (coal_hit) begin
               data_mem[coal_sel] <= push_data;
            end else begin
               valid[tail]    <= 1'b1;
               tag_mem[tail]  <= push_tag;
               data_mem[tail] <= push_data;
               tail           <= tail + 1'b1;
            end
         end
         count <= count_next;
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - directed bench for writeback_buffer (LINE_SIZE=16, DEPTH=2)
module tb_writeback_buffer;

   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          push_valid;
   logic [31:0]   push_addr;
   logic [LW-1:0] push_data;
   logic          push_ready;
   logic [31:0]   lookup_addr;
   logic          lookup_hit;
   logic [LW-1:0] lookup_data;
   logic          mem_is_input_valid;
   logic [31:0]   mem_addr;
   logic          mem_write;
   logic [LW-1:0] mem_din;
   logic          mem_ready;
   logic          is_empty;

   always #5 clk = ~clk;

   writeback_buffer #(.LINE_SIZE(16), .DEPTH(2)) dut (
      .clk                (clk),
      .reset              (reset),
      .push_valid         (push_valid),
      .push_addr          (push_addr),
      .push_data          (push_data),
      .push_ready         (push_ready),
      .lookup_addr        (lookup_addr),
      .lookup_hit         (lookup_hit),
      .lookup_data        (lookup_data),
      .mem_is_input_valid (mem_is_input_valid),
      .mem_addr           (mem_addr),
      .mem_write          (mem_write),
      .mem_din            (mem_din),
      .mem_ready          (mem_ready),
      .is_empty           (is_empty)
   );

   typedef struct {
      logic          pv;
      logic [31:0]   paddr;
      logic [LW-1:0] pdata;
      logic [31:0]   laddr;
      logic          mr;
      logic          epr;
      logic          ehit;
      logic [LW-1:0] eld;
      logic          emv;
      logic [31:0]   emaddr;
      logic [LW-1:0] emdin;
      logic          eempty;
   } vec_t;

   vec_t vq[$];
   int   passed = 0;
   int   total  = 0;

   function automatic logic [LW-1:0] line(input logic [7:0] b);
      return {16{b}};
   endfunction

   function automatic vec_t mk(input logic pv, input logic [31:0] paddr, input logic [LW-1:0] pdata,
                               input logic [31:0] laddr, input logic mr, input logic epr,
                               input logic ehit, input logic [LW-1:0] eld, input logic emv,
                               input logic [31:0] emaddr, input logic [LW-1:0] emdin,
                               input logic eempty);
      vec_t v;
      v.pv = pv; v.paddr = paddr; v.pdata = pdata; v.laddr = laddr; v.mr = mr;
      v.epr = epr; v.ehit = ehit; v.eld = eld; v.emv = emv; v.emaddr = emaddr;
      v.emdin = emdin; v.eempty = eempty;
      return v;
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [LW-1:0] z;
      logic [LW-1:0] a, b, c, d, d1, d2, e5, e6, e7, e8;
      z  = '0;
      a  = line(8'hAA); b  = line(8'hBB); c  = line(8'hCC); d  = line(8'hDD);
      d1 = line(8'h11); d2 = line(8'h22); e5 = line(8'h55); e6 = line(8'h66);
      e7 = line(8'h77); e8 = line(8'h88);

      // pv paddr data laddr mr | pr hit ldata mv maddr din empty
      // single push
      vq.push_back(mk(1, 32'h1234, a,  32'h1234, 1, 1, 0, z,  0, 32'h0,    z,  1));
      vq.push_back(mk(0, 32'h1234, z,  32'h1238, 1, 1, 1, a,  0, 32'h0,    z,  0));
      vq.push_back(mk(0, 32'h1234, z,  32'h1234, 1, 1, 1, a,  1, 32'h1230, a,  0));
      vq.push_back(mk(0, 32'h1234, z,  32'h1234, 1, 1, 0, z,  0, 32'h0,    z,  1));
      // fill and back-pressure
      vq.push_back(mk(1, 32'h0100, b,  32'h0100, 0, 1, 0, z,  0, 32'h0,    z,  1));
      vq.push_back(mk(1, 32'h0200, c,  32'h0200, 0, 1, 0, z,  0, 32'h0,    z,  0));
      vq.push_back(mk(1, 32'h0300, d,  32'h0100, 0, 0, 1, b,  1, 32'h0100, b,  0));
      vq.push_back(mk(0, 32'h0300, z,  32'h0300, 0, 0, 0, z,  1, 32'h0100, b,  0));
      vq.push_back(mk(0, 32'h0300, z,  32'h0200, 1, 0, 1, c,  1, 32'h0100, b,  0));
      vq.push_back(mk(0, 32'h0300, z,  32'h0100, 1, 1, 0, z,  1, 32'h0200, c,  0));
      vq.push_back(mk(0, 32'h0300, z,  32'h0200, 1, 1, 0, z,  0, 32'h0,    z,  1));
      // lookup forwarding, append behind issuing head with same tag
      vq.push_back(mk(1, 32'h0400, d1, 32'h040C, 0, 1, 0, z,  0, 32'h0,    z,  1));
      vq.push_back(mk(0, 32'h0400, z,  32'h040C, 0, 1, 1, d1, 0, 32'h0,    z,  0));
      vq.push_back(mk(1, 32'h0400, d2, 32'h040C, 0, 1, 1, d1, 1, 32'h0400, d1, 0));
      vq.push_back(mk(0, 32'h0400, z,  32'h040C, 0, 1, 1, d2, 1, 32'h0400, d1, 0));
      vq.push_back(mk(0, 32'h0400, z,  32'h040C, 1, 1, 1, d2, 1, 32'h0400, d1, 0));
      vq.push_back(mk(0, 32'h0400, z,  32'h0400, 1, 1, 1, d2, 1, 32'h0400, d2, 0));
      vq.push_back(mk(0, 32'h0400, z,  32'h0400, 0, 1, 0, z,  0, 32'h0,    z,  1));
      // coalesce while full
      vq.push_back(mk(1, 32'h0100, b,  32'h0500, 0, 1, 0, z,  0, 32'h0,    z,  1));
      vq.push_back(mk(1, 32'h0500, e5, 32'h0500, 0, 1, 0, z,  0, 32'h0,    z,  0));
      vq.push_back(mk(1, 32'h0500, e6, 32'h0500, 0, 1, 1, e5, 1, 32'h0100, b,  0));
      vq.push_back(mk(0, 32'h0700, z,  32'h0500, 0, 0, 1, e6, 1, 32'h0100, b,  0));
      vq.push_back(mk(0, 32'h0700, z,  32'h0500, 1, 0, 1, e6, 1, 32'h0100, b,  0));
      vq.push_back(mk(0, 32'h0700, z,  32'h0100, 1, 1, 0, z,  1, 32'h0500, e6, 0));
      vq.push_back(mk(0, 32'h0700, z,  32'h0500, 1, 1, 0, z,  0, 32'h0,    z,  1));
      // push in the same cycle as the handshake
      vq.push_back(mk(1, 32'h0580, e7, 32'h0600, 1, 1, 0, z,  0, 32'h0,    z,  1));
      vq.push_back(mk(0, 32'h0700, z,  32'h0580, 1, 1, 1, e7, 0, 32'h0,    z,  0));
      vq.push_back(mk(1, 32'h0600, e8, 32'h0600, 1, 1, 0, z,  1, 32'h0580, e7, 0));
      vq.push_back(mk(0, 32'h0700, z,  32'h0600, 0, 1, 1, e8, 1, 32'h0600, e8, 0));
      vq.push_back(mk(0, 32'h0700, z,  32'h0600, 1, 1, 1, e8, 1, 32'h0600, e8, 0));
      vq.push_back(mk(0, 32'h0700, z,  32'h0600, 1, 1, 0, z,  0, 32'h0,    z,  1));

      reset = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
      lookup_addr = '0; mem_ready = 1'b0;

      // two reset cycles; outputs checked after the first reset edge
      @(negedge clk);
      #1;
      check("reset mem_valid",   mem_is_input_valid, 1'b0);
      check("reset lookup_hit",  lookup_hit,         1'b0);
      check("reset lookup_data", lookup_data,        z);
      check("reset is_empty",    is_empty,           1'b1);
      check("reset push_ready",  push_ready,         1'b0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vq[i]) begin
         push_valid  = vq[i].pv;
         push_addr   = vq[i].paddr;
         push_data   = vq[i].pdata;
         lookup_addr = vq[i].laddr;
         mem_ready   = vq[i].mr;
         #1;
         check($sformatf("row%0d push_ready", i),  push_ready,         vq[i].epr);
         check($sformatf("row%0d lookup_hit", i),  lookup_hit,         vq[i].ehit);
         check($sformatf("row%0d lookup_data", i), lookup_data,        vq[i].eld);
         check($sformatf("row%0d mem_valid", i),   mem_is_input_valid, vq[i].emv);
         check($sformatf("row%0d mem_write", i),   mem_write,          vq[i].emv);
         check($sformatf("row%0d is_empty", i),    is_empty,           vq[i].eempty);
         if (vq[i].emv) begin
            check($sformatf("row%0d mem_addr", i), mem_addr, vq[i].emaddr);
            check($sformatf("row%0d mem_din", i),  mem_din,  vq[i].emdin);
         end
         @(negedge clk);
      end

      // pointer wrap: DEPTH*3 pushes each coinciding with a handshake
      push_valid = 1'b1; push_addr = 32'h8000; push_data = line(8'h30);
      mem_ready = 1'b1; lookup_addr = 32'h0;
      @(negedge clk);
      push_valid = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         push_valid = 1'b1;
         push_addr  = 32'h8000 + 32'(k) * 32'h40 + 32'h4;
         push_data  = line(8'h30 + 8'(k));
         #1;
         check($sformatf("wrap%0d mem_valid", k),  mem_is_input_valid, 1'b1);
         check($sformatf("wrap%0d mem_addr", k),   mem_addr, 32'h8000 + 32'(k - 1) * 32'h40);
         check($sformatf("wrap%0d mem_din", k),    mem_din, line(8'h30 + 8'(k - 1)));
         check($sformatf("wrap%0d push_ready", k), push_ready, 1'b1);
         @(negedge clk);
      end
      push_valid = 1'b0;
      #1;
      check("wrap last mem_addr", mem_addr, 32'h8180);
      check("wrap last mem_din",  mem_din,  line(8'h36));
      @(negedge clk);
      #1;
      check("wrap drained mem_valid", mem_is_input_valid, 1'b0);
      check("wrap drained is_empty",  is_empty,           1'b1);
      @(negedge clk);

      // long stall with stable request, then reset while issuing with count=2
      mem_ready = 1'b0; lookup_addr = 32'h9000;
      push_valid = 1'b1; push_addr = 32'h9000; push_data = line(8'hE1);
      @(negedge clk);
      push_addr = 32'h9100; push_data = line(8'hE2);
      @(negedge clk);
      push_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("stall%0d mem_valid", k), mem_is_input_valid, 1'b1);
         check($sformatf("stall%0d mem_addr", k),  mem_addr, 32'h9000);
         check($sformatf("stall%0d mem_din", k),   mem_din,  line(8'hE1));
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      check("reset-hi push_ready", push_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post-reset mem_valid",  mem_is_input_valid, 1'b0);
      check("post-reset lookup_hit", lookup_hit,         1'b0);
      check("post-reset is_empty",   is_empty,           1'b1);
      check("post-reset push_ready", push_ready,         1'b1);
      mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("no-reissue%0d mem_valid", k), mem_is_input_valid, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
